// File: rtl/qpsk_symbol_gen.sv
// QPSK waveform generator: plays SPS samples per 2-bit symbol from one shared
// cosine table, with a one-deep symbol buffer, strobe throttling and underflow.
module qpsk_symbol_gen #(
  parameter int OUT_W    = 10,
  parameter int AMP      = 100,
  parameter int SPS_LOG2 = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              sym_in,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  input  logic                    sample_en,
  output logic signed [OUT_W-1:0] sample_out,
  output logic                    out_valid,
  output logic                    sym_start,
  output logic                    underflow
);

  localparam int SPS = 1 << SPS_LOG2;

  typedef logic [SPS_LOG2-1:0] idx_t;
  typedef enum logic {IDLE, RUN} state_t;

  localparam idx_t LAST = idx_t'(SPS - 1);

  // Elaboration-time round(AMP*sqrt(2)*cos(2*pi*k/SPS)) in Q28 fixed point,
  // folding the angle into [0, pi/2] so a short Taylor series stays accurate.
  function automatic longint table_entry(input int k);
    longint one, pi_q, sqrt2_q, x, x2, term, cosv, r, mag, res;
    int q, sgn;
    one     = 64'sd1 <<< 28;
    pi_q    = 64'sd843314857;
    sqrt2_q = 64'sd379625062;
    q   = k % SPS;
    sgn = 1;
    if (q > SPS / 2) q = SPS - q;
    if (q > SPS / 4) begin
      sgn = -1;
      q   = SPS / 2 - q;
    end
    x    = (pi_q * 64'sd2 * longint'(q)) / longint'(SPS);
    x2   = (x * x) / one;
    term = one;
    cosv = one;
    for (int n = 1; n <= 9; n++) begin
      term = -((term * x2) / one) / longint'((2 * n) * (2 * n - 1));
      cosv = cosv + term;
    end
    r   = ((cosv * sqrt2_q) / one) * longint'(sgn) * longint'(AMP);
    mag = (r < 0) ? -r : r;
    res = (mag + one / 64'sd2) / one;
    return (r < 0) ? -res : res;
  endfunction

  // Phase offset that turns the shared cosine into sI*cos + sQ*sin.
  function automatic idx_t sym_offset(input logic [1:0] s);
    case (s)
      2'b00:   return idx_t'(3 * SPS / 8);
      2'b01:   return idx_t'(5 * SPS / 8);
      2'b10:   return idx_t'(SPS / 8);
      default: return idx_t'(7 * SPS / 8);
    endcase
  endfunction

  logic signed [OUT_W-1:0] wtab [SPS];

  for (genvar k = 0; k < SPS; k++) begin : g_tab
    localparam longint VAL = table_entry(k);
    assign wtab[k] = VAL[OUT_W-1:0];
  end

  state_t     state;
  idx_t       counter;
  logic [1:0] cur_sym;
  logic [1:0] next_sym;
  logic       next_full;
  logic       load;
  idx_t       next_idx;

  assign sym_ready = ~next_full;

  // A buffered symbol starts either from idle or seamlessly after the last sample.
  assign load     = sample_en && next_full && (state == IDLE || counter == LAST);
  assign next_idx = counter + idx_t'(1) + sym_offset(cur_sym);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      counter    <= '0;
      cur_sym    <= '0;
      next_sym   <= '0;
      next_full  <= 1'b0;
      sample_out <= '0;
      out_valid  <= 1'b0;
      sym_start  <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      sym_start <= 1'b0;
      underflow <= 1'b0;
      if (sym_valid && !next_full) begin
        next_sym  <= sym_in;
        next_full <= 1'b1;
      end
      if (load) begin
        state      <= RUN;
        cur_sym    <= next_sym;
        next_full  <= 1'b0;
        counter    <= '0;
        sample_out <= wtab[sym_offset(next_sym)];
        out_valid  <= 1'b1;
        sym_start  <= 1'b1;
      end else if (sample_en && state == RUN) begin
        if (counter != LAST) begin
          counter    <= counter + idx_t'(1);
          sample_out <= wtab[next_idx];
          out_valid  <= 1'b1;
        end else begin
          state      <= IDLE;
          counter    <= '0;
          sample_out <= '0;
          underflow  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_qpsk_symbol_gen.sv
// Bench for qpsk_symbol_gen: directed scenarios plus random traffic, compared
// against a model that evaluates sI*A*cos + sQ*A*sin directly.
module tb_qpsk_symbol_gen;

  localparam int OUT_W    = 10;
  localparam int AMP      = 100;
  localparam int SPS_LOG2 = 4;
  localparam int SPS      = 1 << SPS_LOG2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [1:0]              sym_in;
  logic                    sym_valid;
  logic                    sym_ready;
  logic                    sample_en;
  logic signed [OUT_W-1:0] sample_out;
  logic                    out_valid;
  logic                    sym_start;
  logic                    underflow;

  qpsk_symbol_gen #(
    .OUT_W    (OUT_W),
    .AMP      (AMP),
    .SPS_LOG2 (SPS_LOG2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sym_in     (sym_in),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .sample_en  (sample_en),
    .sample_out (sample_out),
    .out_valid  (out_valid),
    .sym_start  (sym_start),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference state: one buffered symbol, the playing symbol and its sample number.
  logic [1:0] offer_q[$];
  bit         m_full;
  logic [1:0] m_buf;
  bit         m_active;
  logic [1:0] m_cur;
  int         m_n;
  int         exp_sample;
  bit         exp_valid;
  bit         exp_start;
  bit         exp_under;

  function automatic int refSample(input logic [1:0] s, input int n);
    real si, sq, th, v;
    si = s[1] ? 1.0 : -1.0;
    sq = s[0] ? 1.0 : -1.0;
    th = 2.0 * 3.14159265358979 * n / SPS;
    v  = si * AMP * $cos(th) + sq * AMP * $sin(th);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  task automatic resetModel();
    m_full     = 1'b0;
    m_buf      = 2'b00;
    m_active   = 1'b0;
    m_cur      = 2'b00;
    m_n        = 0;
    exp_sample = 0;
    exp_valid  = 1'b0;
    exp_start  = 1'b0;
    exp_under  = 1'b0;
  endtask

  task automatic checkVal(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".sample_out"}, sample_out, exp_sample);
    checkVal({tag, ".out_valid"},  out_valid,  exp_valid);
    checkVal({tag, ".sym_start"},  sym_start,  exp_start);
    checkVal({tag, ".underflow"},  underflow,  exp_under);
    checkVal({tag, ".sym_ready"},  sym_ready,  !m_full);
  endtask

  // One clock: offer the head of offer_q, strobe if en, then advance the model and compare.
  task automatic applyStimulus(input bit en, input string tag);
    bit         v;
    bit         acc;
    logic [1:0] s;
    v         = offer_q.size() > 0;
    s         = v ? offer_q[0] : 2'($urandom_range(0, 3));
    sym_valid = v;
    sym_in    = s;
    sample_en = en;
    acc       = v && !m_full;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    exp_start = 1'b0;
    exp_under = 1'b0;
    if (en) begin
      if (m_full && (!m_active || m_n == SPS - 1)) begin
        m_cur      = m_buf;
        m_full     = 1'b0;
        m_active   = 1'b1;
        m_n        = 0;
        exp_sample = refSample(m_cur, 0);
        exp_valid  = 1'b1;
        exp_start  = 1'b1;
      end else if (m_active && m_n < SPS - 1) begin
        m_n        = m_n + 1;
        exp_sample = refSample(m_cur, m_n);
        exp_valid  = 1'b1;
      end else if (m_active) begin
        m_active   = 1'b0;
        exp_sample = 0;
        exp_under  = 1'b1;
      end
    end
    if (acc) begin
      m_full = 1'b1;
      m_buf  = s;
      void'(offer_q.pop_front());
    end
    checkOutput(tag);
  endtask

  initial begin
    int guard;
    rst       = 1'b0;
    sym_valid = 1'b0;
    sym_in    = 2'b00;
    sample_en = 1'b0;
    resetModel();

    #1 rst = 1'b1;
    #1 checkOutput("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_release");

    offer_q = '{2'b00};
    repeat (18) applyStimulus(1'b1, "sym00");

    offer_q = '{2'b11};
    repeat (19) applyStimulus(1'b1, "sym11_alone");

    offer_q = '{2'b00, 2'b10};
    repeat (36) applyStimulus(1'b1, "back_to_back");

    offer_q = '{2'b01};
    for (int i = 0; i < 60; i++) applyStimulus(i % 3 == 0, "strobe3");

    offer_q = '{2'b00, 2'b11, 2'b10};
    repeat (60) applyStimulus(1'b1, "three_queued");

    // Reset lands mid-symbol at sample 7 while the next symbol is buffered.
    offer_q = '{2'b11, 2'b01};
    guard = 0;
    while (!(m_active && m_n == 6 && m_full) && guard < 40) begin
      applyStimulus(1'b1, "pre_reset");
      guard++;
    end
    checkVal("reset_point_reached", guard < 40, 1);
    #3 rst = 1'b1;
    #1 resetModel();
    checkOutput("async_reset");
    @(posedge clk);
    #1 checkOutput("reset_held");
    rst = 1'b0;
    offer_q.delete();
    repeat (6) applyStimulus(1'b1, "post_reset_idle");

    for (int i = 0; i < 800; i++) begin
      if (offer_q.size() == 0 && $urandom_range(0, 2) == 0)
        offer_q.push_back(2'($urandom_range(0, 3)));
      applyStimulus($urandom_range(0, 3) != 0, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/qpsk_symbol_gen.md
Name: qpsk_symbol_gen

Overview:
- Parametrised QPSK waveform generator for the modulator datapath.
- Accepts 2-bit symbols through a valid/ready handshake and buffers one symbol ahead.
- Emits SPS signed samples per symbol from a single shared cosine table, selecting the phase offset per symbol.
- Replaces the four fixed-table, free-running per-symbol generators with one block that adds symbol sequencing, sample-rate throttling and underflow reporting.

Parameters:
- OUT_W, 10, width of signed sample output.
- AMP, 100, per-quadrature amplitude A. Table peak is round(A*sqrt(2)) and must fit in OUT_W signed.
- SPS_LOG2, 4, log2 of samples per symbol (SPS = 2^SPS_LOG2). Must be >= 3.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- sym_in, input, 2, symbol bits {b1,b0}.
- sym_valid, input, 1, sym_in valid.
- sym_ready, output, 1, block can accept a symbol.
- sample_en, input, 1, sample-rate strobe; one output sample is produced per asserted cycle.
- sample_out, output, OUT_W, signed waveform sample (registered).
- out_valid, output, 1, one-cycle pulse: sample_out updated with a new active sample.
- sym_start, output, 1, one-cycle pulse coincident with the first sample of each symbol.
- underflow, output, 1, one-cycle pulse when a symbol ends with no next symbol buffered.

Behaviour:
- Clock is clk. Reset rst is asynchronous and active-high.
- Reset clears all state and outputs: sample_out=0, out_valid=0, sym_start=0, underflow=0, state=IDLE, counter=0, next_full=0. Reset mid-symbol aborts the symbol and discards the buffered symbol.
- Table: W[k] = round(AMP*sqrt(2)*cos(2*pi*k/SPS)) for k = 0..SPS-1, computed at elaboration. Round half away from zero.
- Symbol mapping: waveform = sI*A*cos + sQ*A*sin, with sI = b1 ? +1 : -1 and sQ = b0 ? +1 : -1. This is realised as W[(counter + OFF) mod SPS]:
  - 00: OFF = 3*SPS/8
  - 01: OFF = 5*SPS/8
  - 10: OFF = SPS/8
  - 11: OFF = 7*SPS/8
- Index arithmetic is unsigned SPS_LOG2 bits and wraps naturally.
- Holding buffer: one entry (next_sym, next_full).
  - sym_ready = ~next_full (combinational).
  - Accept on sym_valid & sym_ready; next_full is set the following cycle.
  - A symbol accepted in cycle t can be loaded no earlier than a sample_en in cycle t+1.
- State IDLE:
  - sample_en & next_full: load cur_sym=next_sym, clear next_full, counter=0, go RUN. Next cycle: sample_out=W[OFF], out_valid=1, sym_start=1.
  - sample_en & ~next_full: no output change, out_valid=0, no underflow.
- State RUN, on each sample_en:
  - counter < SPS-1: counter+1, emit next sample, out_valid=1.
  - counter == SPS-1 and next_full: load the new symbol, counter=0, emit its first sample with sym_start=1. There is no gap between symbols.
  - counter == SPS-1 and ~next_full: go IDLE. Next cycle: sample_out=0, out_valid=0, underflow=1 for one cycle.
- Latency: one cycle from sample_en to the sample_out/out_valid update.
- sample_en low: all state and sample_out hold; out_valid, sym_start and underflow are 0.
- A symbol accept and a buffer drain cannot occur in the same cycle, since sym_ready=0 while full. The upstream has SPS-1 sample periods to refill the buffer.

Test Plan:
- Reset; push 00; sample_en=1 continuously -> sample_out = -100,-131,-141,-131,-100,-54,0,54,100,131,141,131,100,54,0,-54. sym_start on the first sample only; out_valid high for 16 cycles.
- Push 11 alone -> first 7 samples 100,131,141,131,100,54,0; then 16th sample 54; underflow pulse one cycle after; sample_out=0.
- Push 00 then 10 back-to-back -> 16 samples of 00 followed immediately by 100,54,0,-54,... with sym_start on sample 17; no underflow.
- sample_en every 3rd cycle, symbol 01 -> sequence -100,-54,0,54,100,131,... (symbol 01 gives W[(k+10) mod 16]). Outputs hold between strobes; out_valid pulses only after strobes; sym_ready low from accept until load.
- Two symbols offered while the first is playing -> second is accepted and held with sym_ready=0 until the first's last sample; third is stalled with no loss; order is preserved.
- Assert rst asynchronously at sample 7 of a symbol with the buffer full -> outputs 0 immediately, sym_ready=1 next cycle. After release, sample_en with no symbol produces nothing and no underflow.
